// File: rtl/lcd_pkg.sv
// Shared types and constants for the HD44780 bus-timing sequencer.
package lcd_pkg;

    typedef enum logic [2:0] {
        StInitWait,
        StInitIssue,
        StIdle,
        StSetup,
        StPulse,
        StHold,
        StExec
    } lcd_state_e;

    localparam logic [7:0] CMD_CLEAR        = 8'h01;
    localparam logic [7:0] CMD_HOME         = 8'h02;
    localparam logic [7:0] CMD_FUNC_8BIT_2L = 8'h38;
    localparam logic [7:0] CMD_DISP_ON      = 8'h0C;
    localparam logic [7:0] CMD_ENTRY_INC    = 8'h06;

    localparam int unsigned INIT_LEN = 6;
    // Index 0 is issued first.
    localparam logic [INIT_LEN-1:0][7:0] INIT_ROM = {
        CMD_ENTRY_INC, CMD_CLEAR, CMD_DISP_ON,
        CMD_FUNC_8BIT_2L, CMD_FUNC_8BIT_2L, CMD_FUNC_8BIT_2L
    };

    function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

    // Clear (0x01) and home (0x02/0x03) need the long execution wait.
    function automatic logic is_long_exec(input logic rs, input logic [7:0] data);
        return !rs && ((data == CMD_CLEAR) || (data[7:1] == CMD_HOME[7:1]));
    endfunction

endpackage

// File: rtl/lcd_cmd_fifo.sv
// Synchronous FIFO of {rs, data} entries queued for the LCD bus sequencer.
module lcd_cmd_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 9
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             push_i,
    input  logic [WIDTH-1:0] push_data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] pop_data_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] PTR_ONE = 1;

    logic [PTR_W:0]              wr_ptr_q, wr_ptr_d;
    logic [PTR_W:0]              rd_ptr_q, rd_ptr_d;
    logic [DEPTH-1:0][WIDTH-1:0] mem_q, mem_d;
    logic                        do_push, do_pop;

    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign full_o  = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                     (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);

    // A full FIFO still takes a push when the head leaves on the same edge.
    assign do_pop     = pop_i && !empty_o;
    assign do_push    = push_i && (!full_o || do_pop);
    assign pop_data_o = mem_q[rd_ptr_q[PTR_W-1:0]];

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (do_push) begin
            mem_d[wr_ptr_q[PTR_W-1:0]] = push_data_i;
            wr_ptr_d                   = wr_ptr_q + PTR_ONE;
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mem_q    <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

endmodule

// File: rtl/lcd_hd44780_sequencer.sv
// HD44780 8-bit write-only bus-timing engine fed by a small command FIFO.
// Define LCD_INIT_SEQ_EN to add the power-up wait and the built-in init sequence.
module lcd_hd44780_sequencer
    import lcd_pkg::*;
#(
    parameter int unsigned CLK_HZ         = 50_000_000,
    parameter int unsigned SETUP_CYC      = 3,
    parameter int unsigned PULSE_CYC      = 25,
    parameter int unsigned HOLD_CYC       = 3,
    parameter int unsigned EXEC_SHORT_CYC = 2000,
    parameter int unsigned EXEC_LONG_CYC  = 80000,
    parameter int unsigned POWERUP_CYC    = 2_000_000,
    parameter int unsigned FIFO_DEPTH     = 4
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic       in_rs,
    input  logic [7:0] in_data,
    output logic       busy,
    output logic [7:0] lcd_data,
    output logic       lcd_rs,
    output logic       lcd_rw,
    output logic       lcd_en
);

    localparam int unsigned MAX_CYC = max_u(max_u(max_u(SETUP_CYC, PULSE_CYC),
        max_u(HOLD_CYC, EXEC_SHORT_CYC)), max_u(max_u(EXEC_LONG_CYC, POWERUP_CYC), 2));
    localparam int unsigned CNT_W = $clog2(MAX_CYC);

    localparam logic [CNT_W-1:0] CNT_ONE    = 1;
    localparam logic [CNT_W-1:0] SETUP_LOAD = CNT_W'(SETUP_CYC - 1);
    localparam logic [CNT_W-1:0] PULSE_LOAD = CNT_W'(PULSE_CYC - 1);
    localparam logic [CNT_W-1:0] HOLD_LOAD  = CNT_W'(HOLD_CYC - 1);
    localparam logic [CNT_W-1:0] SHORT_LOAD = CNT_W'(EXEC_SHORT_CYC - 1);
    localparam logic [CNT_W-1:0] LONG_LOAD  = CNT_W'(EXEC_LONG_CYC - 1);

    if (CLK_HZ == 0 || SETUP_CYC == 0 || PULSE_CYC == 0 || HOLD_CYC == 0 ||
        EXEC_SHORT_CYC == 0 || EXEC_LONG_CYC == 0 || POWERUP_CYC == 0) begin : g_bad_cyc
        $error("lcd_hd44780_sequencer: clock and cycle parameters must be non-zero");
    end
    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
        $error("lcd_hd44780_sequencer: FIFO_DEPTH must be a power of 2 and >= 2");
    end

    lcd_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [7:0]       lcd_data_q, lcd_data_d;
    logic             lcd_rs_q, lcd_rs_d;
    logic             out_of_reset_q;
    logic             fifo_pop, fifo_push, fifo_full, fifo_empty;
    logic [8:0]       fifo_rdata;

`ifdef LCD_INIT_SEQ_EN
    localparam int unsigned      IDX_W        = $clog2(INIT_LEN + 1);
    localparam logic [IDX_W-1:0] IDX_ONE      = 1;
    localparam logic [IDX_W-1:0] IDX_LAST     = IDX_W'(INIT_LEN);
    localparam logic [CNT_W-1:0] POWERUP_LOAD = CNT_W'(POWERUP_CYC - 1);
    logic [IDX_W-1:0] init_idx_q, init_idx_d;
`endif

    assign fifo_push = in_valid && in_ready;

    lcd_cmd_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (9)
    ) u_fifo (
        .clk         (clk),
        .reset_n     (reset_n),
        .push_i      (fifo_push),
        .push_data_i ({in_rs, in_data}),
        .pop_i       (fifo_pop),
        .pop_data_o  (fifo_rdata),
        .full_o      (fifo_full),
        .empty_o     (fifo_empty)
    );

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        lcd_data_d = lcd_data_q;
        lcd_rs_d   = lcd_rs_q;
        fifo_pop   = 1'b0;
`ifdef LCD_INIT_SEQ_EN
        init_idx_d = init_idx_q;
`endif
        unique case (state_q)
`ifdef LCD_INIT_SEQ_EN
            StInitWait: begin
                if (cnt_q == '0) state_d = StInitIssue;
                else             cnt_d   = cnt_q - CNT_ONE;
            end
            StInitIssue: begin
                state_d    = StSetup;
                cnt_d      = SETUP_LOAD;
                lcd_data_d = INIT_ROM[init_idx_q];
                lcd_rs_d   = 1'b0;
                init_idx_d = init_idx_q + IDX_ONE;
            end
`endif
            StIdle: begin
                if (!fifo_empty) begin
                    fifo_pop               = 1'b1;
                    {lcd_rs_d, lcd_data_d} = fifo_rdata;
                    state_d                = StSetup;
                    cnt_d                  = SETUP_LOAD;
                end
            end
            StSetup: begin
                if (cnt_q == '0) begin
                    state_d = StPulse;
                    cnt_d   = PULSE_LOAD;
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            StPulse: begin
                if (cnt_q == '0) begin
                    state_d = StHold;
                    cnt_d   = HOLD_LOAD;
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            StHold: begin
                if (cnt_q == '0) begin
                    state_d = StExec;
                    cnt_d   = is_long_exec(lcd_rs_q, lcd_data_q) ? LONG_LOAD : SHORT_LOAD;
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            StExec: begin
                if (cnt_q == '0) begin
`ifdef LCD_INIT_SEQ_EN
                    state_d = (init_idx_q == IDX_LAST) ? StIdle : StInitIssue;
`else
                    state_d = StIdle;
`endif
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
`ifdef LCD_INIT_SEQ_EN
            state_q    <= StInitWait;
            cnt_q      <= POWERUP_LOAD;
            init_idx_q <= '0;
`else
            state_q    <= StIdle;
            cnt_q      <= '0;
`endif
            lcd_data_q     <= '0;
            lcd_rs_q       <= 1'b0;
            out_of_reset_q <= 1'b0;
        end else begin
`ifdef LCD_INIT_SEQ_EN
            init_idx_q <= init_idx_d;
`endif
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            lcd_data_q     <= lcd_data_d;
            lcd_rs_q       <= lcd_rs_d;
            out_of_reset_q <= 1'b1;
        end
    end

    assign in_ready = out_of_reset_q && !fifo_full;
    assign busy     = (state_q != StIdle) || !fifo_empty;
    assign lcd_data = lcd_data_q;
    assign lcd_rs   = lcd_rs_q;
    assign lcd_rw   = 1'b0;
    assign lcd_en   = (state_q == StPulse);

endmodule
